// File: rtl/instr_encoder_pkg.sv
// tessia_enc_pkg: shared definitions for the instruction encoder.
//   - kind / alu_cmd enums (3-bit input codes)
//   - funct[4:1] ALU constants, op constants, condition constants
//   - instruction word field bit positions
//   - helpers: alu_funct() lookup, is_illegal() legality check
package tessia_enc_pkg;

  typedef enum logic [2:0] {
    KIND_DP_REG = 3'd0,
    KIND_DP_IMM = 3'd1,
    KIND_LDR    = 3'd2,
    KIND_STR    = 3'd3,
    KIND_B      = 3'd4
  } kind_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_ORR = 3'd3,
    ALU_MOV = 3'd4,
    ALU_CMP = 3'd5
  } alu_cmd_e;

  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_MUL = 4'b0000;
  localparam logic [3:0] FN_ORR = 4'b1100;
  localparam logic [3:0] FN_MOV = 4'b1101;
  localparam logic [3:0] FN_CMP = 4'b1010;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] BR_TAG = 2'b10;

  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int COND_LSB   = 28;
  localparam int OP_LSB     = 26;
  localparam int FUNCT_LSB  = 20;
  localparam int BR_TAG_LSB = 24;
  localparam int RN_LSB     = 16;
  localparam int RD_LSB     = 12;
  localparam int SRC2_LSB   = 0;
  localparam int IMM24_LSB  = 0;

  // Undefined ALU codes map to 0000.
  function automatic logic [3:0] alu_funct(input logic [2:0] cmd);
    case (cmd)
      ALU_ADD: return FN_ADD;
      ALU_SUB: return FN_SUB;
      ALU_MUL: return FN_MUL;
      ALU_ORR: return FN_ORR;
      ALU_MOV: return FN_MOV;
      ALU_CMP: return FN_CMP;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] kind,
                                      input logic [2:0] cmd,
                                      input logic [3:0] rd);
    logic dp;
    dp = (kind == KIND_DP_REG) || (kind == KIND_DP_IMM);
    return (kind > KIND_B) || (cmd > ALU_CMP) || (dp && (rd == 4'hF));
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field handshake plus memory-write bus.
//   master: field producer / memory side (drives in_valid, fields, mem_ready)
//   slave : encoder (drives in_ready, mem_we, mem_addr, mem_wdata)
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        kind;
  logic [2:0]        alu_cmd;
  logic              set_flags;
  logic [3:0]        cond;
  logic [3:0]        rd;
  logic [3:0]        rn;
  logic [11:0]       src2;
  logic [23:0]       imm24;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, kind, alu_cmd, set_flags, cond, rd, rn, src2, imm24, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, kind, alu_cmd, set_flags, cond, rd, rn, src2, imm24, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: stateless field-to-word packing.
//   in : kind, alu_cmd, set_flags, cond, rd, rn, src2, imm24
//   out: word (32-bit encoded instruction)
// Kinds outside the defined set pack with the data-processing layout.
module instr_pack
  import tessia_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  alu_cmd,
  input  logic        set_flags,
  input  logic [3:0]  cond,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  output logic [31:0] word
);
  always_comb begin
    word = '0;
    word[COND_LSB +: 4] = cond;
    case (kind)
      KIND_LDR, KIND_STR: begin
        word[OP_LSB +: 2]    = OP_MEM;
        word[FUNCT_LSB +: 6] = {1'b1, 4'b0000, (kind == KIND_LDR)};
        word[RN_LSB +: 4]    = rn;
        word[RD_LSB +: 4]    = rd;
        word[SRC2_LSB +: 12] = src2;
      end
      KIND_B: begin
        word[OP_LSB +: 2]     = OP_BR;
        word[BR_TAG_LSB +: 2] = BR_TAG;
        word[IMM24_LSB +: 24] = imm24;
      end
      default: begin
        word[OP_LSB +: 2]    = OP_DP;
        // CMP always updates flags regardless of set_flags.
        word[FUNCT_LSB +: 6] = {(kind == KIND_DP_IMM), alu_funct(alu_cmd),
                                set_flags | (alu_cmd == ALU_CMP)};
        word[RN_LSB +: 4]    = rn;
        word[RD_LSB +: 4]    = rd;
        word[SRC2_LSB +: 12] = src2;
      end
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction fields, encodes them, and writes the
// words to sequential instruction-memory addresses starting at BASE_ADDR.
//   clk, reset (sync, active low), start (session start / abort pulse)
//   bus    : instr_encoder_if.slave (field handshake + memory write)
//   busy   : ACCEPT or WRITE
//   full   : last address written, no further words accepted
//   done   : one-cycle pulse on entering FULL
//   count  : words written this session
//   err    : sticky illegal-word flag (only with ENC_CHECK_EN defined)
// Optional feature macro: ENC_CHECK_EN.
module instr_encoder
  import tessia_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_encoder_if.slave      bus,
  output logic                busy,
  output logic                full,
  output logic                done,
  output logic [ADDR_W:0]     count
`ifdef ENC_CHECK_EN
  ,
  output logic                err
`endif
);
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_FULL
  } state_e;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [31:0]       packed_word;
`ifdef ENC_CHECK_EN
  logic              err_q, err_d;
  logic              illegal;
  assign illegal = is_illegal(bus.kind, bus.alu_cmd, bus.rd);
`endif

  instr_pack u_pack (
    .kind      (bus.kind),
    .alu_cmd   (bus.alu_cmd),
    .set_flags (bus.set_flags),
    .cond      (bus.cond),
    .rd        (bus.rd),
    .rn        (bus.rn),
    .src2      (bus.src2),
    .imm24     (bus.imm24),
    .word      (packed_word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
`ifdef ENC_CHECK_EN
    err_d   = err_q;
`endif
    if (start) begin
      // Start from any state restarts the session, dropping a pending word.
      state_d = ST_ACCEPT;
      addr_d  = BASE;
      count_d = '0;
`ifdef ENC_CHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          if (bus.in_valid) begin
`ifdef ENC_CHECK_EN
            if (illegal) begin
              err_d = 1'b1;
            end else begin
              wdata_d = packed_word;
              state_d = ST_WRITE;
            end
`else
            wdata_d = packed_word;
            state_d = ST_WRITE;
`endif
          end
        end
        ST_WRITE: begin
          if (bus.mem_ready) begin
            count_d = count_q + 1'b1;
            if (addr_q == '1) begin
              state_d = ST_FULL;
              done_d  = 1'b1;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_ACCEPT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
`ifdef ENC_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
`ifdef ENC_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // mem_we is masked while reset or start is asserted so an aborted word
  // can never be committed in the same cycle it is dropped.
  assign bus.in_ready  = (state_q == ST_ACCEPT);
  assign bus.mem_we    = (state_q == ST_WRITE) && reset && !start;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
  assign full          = (state_q == ST_FULL);
  assign done          = done_q;
  assign count         = count_q;
`ifdef ENC_CHECK_EN
  assign err           = err_q;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2, BASE_ADDR=0).
module tb_instr_encoder;
  localparam int AW = 2;
  localparam int unsigned LAST_ADDR = (1 << AW) - 1;
  // ALU funct[4:1] by alu_cmd code; codes 6/7 are undefined and encode as 0.
  localparam int unsigned FN_TAB [8] = '{4, 2, 0, 12, 13, 10, 0, 0};

  logic clk;
  logic rst_n;
  logic start;
  logic busy, full, done;
  logic [AW:0] count;
`ifdef ENC_CHECK_EN
  logic err;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int unsigned m_addr = 0;
  int unsigned m_count = 0;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .full  (full),
    .done  (done),
    .count (count)
`ifdef ENC_CHECK_EN
    ,
    .err   (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time limit)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input int unsigned k, a, sf, c, rd, rn, s2, i24);
    logic [31:0] w;
    w = 32'(c) << 28;
    if (k == 4) begin
      w = w | (32'd2 << 26) | (32'd2 << 24) | 32'(i24);
    end else if (k == 2 || k == 3) begin
      w = w | (32'd1 << 26) | (32'd1 << 25) | (32'(k == 2) << 20)
            | (32'(rn) << 16) | (32'(rd) << 12) | 32'(s2);
    end else begin
      w = w | (32'(k == 1) << 25) | (32'(FN_TAB[a]) << 21)
            | (32'((sf != 0) || (a == 5)) << 20)
            | (32'(rn) << 16) | (32'(rd) << 12) | 32'(s2);
    end
    return w;
  endfunction

  task automatic drive_fields(input int unsigned k, a, sf, c, rd, rn, s2, i24);
    bus.kind      = 3'(k);
    bus.alu_cmd   = 3'(a);
    bus.set_flags = 1'(sf);
    bus.cond      = 4'(c);
    bus.rd        = 4'(rd);
    bus.rn        = 4'(rn);
    bus.src2      = 12'(s2);
    bus.imm24     = 24'(i24);
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_addr  = 0;
    m_count = 0;
    chk("start_in_ready", 32'(bus.in_ready), 1);
    chk("start_addr", 32'(bus.mem_addr), 0);
    chk("start_count", 32'(count), 0);
  endtask

  // One word through ACCEPT -> WRITE, with `stall` cycles of mem_ready low.
  task automatic send(input int unsigned k, a, sf, c, rd, rn, s2, i24, input int unsigned stall);
    logic [31:0] exp;
    bit last;
    exp = model_word(k, a, sf, c, rd, rn, s2, i24);
    drive_fields(k, a, sf, c, rd, rn, s2, i24);
    bus.in_valid  = 1'b1;
    bus.mem_ready = 1'b0;
    chk("acc_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    drive_fields($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < int'(stall); i++) begin
      chk("stall_we", 32'(bus.mem_we), 1);
      chk("stall_data", bus.mem_wdata, exp);
      chk("stall_addr", 32'(bus.mem_addr), m_addr);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_count", 32'(count), m_count);
      tick();
    end
    bus.mem_ready = 1'b1;
    chk("wr_we", 32'(bus.mem_we), 1);
    chk("wr_data", bus.mem_wdata, exp);
    chk("wr_addr", 32'(bus.mem_addr), m_addr);
    tick();
    bus.mem_ready = 1'b0;
    last = (m_addr == LAST_ADDR);
    m_count++;
    if (!last) m_addr++;
    chk("post_count", 32'(count), m_count);
    chk("post_full", 32'(full), 32'(last));
    chk("post_done", 32'(done), 32'(last));
    chk("post_in_ready", 32'(bus.in_ready), 32'(!last));
    chk("post_we", 32'(bus.mem_we), 0);
  endtask

  task automatic rand_send();
    int unsigned k, a;
    k = $urandom_range(0, 4);
`ifdef ENC_CHECK_EN
    a = $urandom_range(0, 5);
`else
    a = $urandom_range(0, 7);
`endif
    send(k, a, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 14),
         $urandom_range(0, 15), $urandom_range(0, 4095), $urandom_range(0, 24'hFFFFFF),
         $urandom_range(0, 2));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b0;
    drive_fields(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 0);

    // Directed encodings, one stalled write, then the fill to FULL.
    start_session();
    chk("accept_busy", 32'(busy), 1);
    chk("enc_dp_imm", model_word(1, 0, 0, 14, 1, 2, 5, 0), 32'hE2821005);
    send(1, 0, 0, 14, 1, 2, 12'h005, 0, 0);
    send(2, 0, 0, 14, 3, 4, 12'h008, 0, 3);
    send(4, 0, 0, 14, 0, 0, 0, 24'h000010, 0);
    send(0, 5, 0, 14, 0, 1, 12'h002, 0, 0);

    // Fifth word offered while FULL must be ignored.
    drive_fields(1, 0, 0, 14, 1, 2, 5, 0);
    bus.in_valid  = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_in_ready", 32'(bus.in_ready), 0);
      chk("full_we", 32'(bus.mem_we), 0);
      chk("full_flag", 32'(full), 1);
      chk("full_done", 32'(done), 0);
      chk("full_count", 32'(count), 4);
      chk("full_busy", 32'(busy), 0);
    end
    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b0;

    // Randomised sessions, each filling the memory.
    for (int s = 0; s < 6; s++) begin
      start_session();
      for (int w = 0; w < 4; w++) rand_send();
    end

    // Abort during WRITE.
    start_session();
    rand_send();
    drive_fields(3, 0, 0, 14, 5, 6, 12'h123, 0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("abort_pre_we", 32'(bus.mem_we), 1);
    chk("abort_pre_addr", 32'(bus.mem_addr), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_addr  = 0;
    m_count = 0;
    chk("abort_we", 32'(bus.mem_we), 0);
    chk("abort_addr", 32'(bus.mem_addr), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    rand_send();

    // Reset while a word is pending in WRITE.
    drive_fields(2, 0, 0, 14, 7, 8, 12'h0FF, 0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_we", 32'(bus.mem_we), 1);
    rst_n = 1'b0;
    tick();
    chk("mrst_in_ready", 32'(bus.in_ready), 0);
    chk("mrst_we", 32'(bus.mem_we), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_full", 32'(full), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_wdata", bus.mem_wdata, 0);
    chk("mrst_addr", 32'(bus.mem_addr), 0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    chk("idle_again_in_ready", 32'(bus.in_ready), 0);
    chk("idle_again_we", 32'(bus.mem_we), 0);
    bus.mem_ready = 1'b0;

`ifdef ENC_CHECK_EN
    start_session();
    drive_fields(0, 0, 0, 14, 15, 1, 12'h001, 0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("ill_err", 32'(err), 1);
    chk("ill_we", 32'(bus.mem_we), 0);
    chk("ill_in_ready", 32'(bus.in_ready), 1);
    chk("ill_count", 32'(count), 0);
    start_session();
    chk("ill_err_clr", 32'(err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
